// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states, opcodes, ALU ops and mux selects.
// S_TRAP exists only when CTRL_ILLEGAL_TRAP_EN is defined.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALUWB     = 4'd8,
    S_BRANCH    = 4'd9,
    S_JALR_ADDR = 4'd10,
    S_JUMP      = 4'd11,
    S_LUI       = 4'd12,
    S_AUIPC     = 4'd13
`ifdef CTRL_ILLEGAL_TRAP_EN
    , S_TRAP    = 4'd14
`endif
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_R      = 7'd51;
  localparam logic [6:0] OP_I      = 7'd19;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JAL    = 7'd111;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_AUIPC  = 7'd23;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  // FSM request to the ALU decoder: forced ADD, forced SUB, or decode from funct fields.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Reduced branch support resolves only beq/bne; the signed/unsigned compares are never taken.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                        input logic lt, input logic ltu, input logic full);
    logic taken;
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = full & lt;
      3'b101:  taken = full & !lt;
      3'b110:  taken = full & ltu;
      3'b111:  taken = full & !ltu;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/multicycle_controlunit_alu_decoder.sv
// Combinational ALU operation decoder: honours the FSM's ADD/SUB override, otherwise decodes funct3/funct7[5].
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  input  logic [1:0] alu_op_i,
  output logic [3:0] ALUCtrl_o
);

  always_comb begin
    ALUCtrl_o = ALU_ADD;
    if (alu_op_i == ALUOP_SUB) begin
      ALUCtrl_o = ALU_SUB;
    end else if (alu_op_i == ALUOP_FUNCT) begin
      case (funct3_i)
        // funct7[5] of an I-type is an immediate bit, so SUB is restricted to register ops.
        3'b000:  ALUCtrl_o = (op_i == OP_R && funct7_5_i) ? ALU_SUB : ALU_ADD;
        3'b001:  ALUCtrl_o = ALU_SLL;
        3'b010:  ALUCtrl_o = ALU_SLT;
        3'b011:  ALUCtrl_o = ALU_SLTU;
        3'b100:  ALUCtrl_o = ALU_XOR;
        3'b101:  ALUCtrl_o = funct7_5_i ? ALU_SRA : ALU_SRL;
        3'b110:  ALUCtrl_o = ALU_OR;
        default: ALUCtrl_o = ALU_AND;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controlunit.sv
// Multi-cycle RV32I control FSM sharing one memory port between fetch and data access.
// Define CTRL_ILLEGAL_TRAP_EN to add the TRAP state and the sticky Illegal_o flag.
module multicycle_controlunit
  import riscv_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ALU_CTRL_W  = 4,
  parameter int BRANCH_FULL = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] Instr_i,
  input  logic                  Zero_i,
  input  logic                  Lt_i,
  input  logic                  Ltu_i,
  input  logic                  MemReady_i,
  output logic                  PCWrite_o,
  output logic                  AdrSrc_o,
  output logic                  IRWrite_o,
  output logic                  MemRead_o,
  output logic                  MemWrite_o,
  output logic                  RegWrite_o,
  output logic [1:0]            ALUSrcA_o,
  output logic [1:0]            ALUSrcB_o,
  output logic [ALU_CTRL_W-1:0] ALUCtrl_o,
  output logic [2:0]            ImmSrc_o,
  output logic [1:0]            ResultSrc_o,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic                  Illegal_o,
`endif
  output logic [3:0]            dbg_state_o
);

  state_t     state_q, state_d;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic [1:0] alu_op;
  logic [3:0] alu_ctrl;
  logic       unused_instr;

  assign opcode       = Instr_i[6:0];
  assign funct3       = Instr_i[14:12];
  assign funct7_5     = Instr_i[30];
  assign unused_instr = ^Instr_i;
  assign dbg_state_o  = state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (MemReady_i) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JUMP;
          OP_JALR:           state_d = S_JALR_ADDR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          // Unknown opcode retires as a NOP; PC already advanced in FETCH.
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:    state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:   if (MemReady_i) state_d = S_MEMWB;
      S_MEMWB:     state_d = S_FETCH;
      S_MEMWRITE:  if (MemReady_i) state_d = S_FETCH;
      S_EXEC_R,
      S_EXEC_I:    state_d = S_ALUWB;
      S_ALUWB:     state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JALR_ADDR: state_d = S_JUMP;
      S_JUMP:      state_d = S_ALUWB;
      S_LUI,
      S_AUIPC:     state_d = S_ALUWB;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP:      state_d = S_TRAP;
`endif
      default:     state_d = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite_o   = 1'b0;
    AdrSrc_o    = 1'b0;
    IRWrite_o   = 1'b0;
    MemRead_o   = 1'b0;
    MemWrite_o  = 1'b0;
    RegWrite_o  = 1'b0;
    ALUSrcA_o   = SRCA_PC;
    ALUSrcB_o   = SRCB_RS2;
    alu_op      = ALUOP_ADD;
    ImmSrc_o    = IMM_I;
    ResultSrc_o = RES_ALUOUT;
    case (state_q)
      S_FETCH: begin
        MemRead_o   = 1'b1;
        ALUSrcB_o   = SRCB_FOUR;
        ResultSrc_o = RES_ALURESULT;
        IRWrite_o   = MemReady_i;
        PCWrite_o   = MemReady_i;
      end
      S_DECODE: begin
        // Branch/jal target is precomputed into ALUOut while the opcode is decoded.
        ALUSrcA_o = SRCA_OLDPC;
        ALUSrcB_o = SRCB_IMM;
        ImmSrc_o  = (opcode == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        ALUSrcA_o = SRCA_RS1;
        ALUSrcB_o = SRCB_IMM;
        ImmSrc_o  = (opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        AdrSrc_o  = 1'b1;
        MemRead_o = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc_o = RES_READDATA;
        RegWrite_o  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc_o   = 1'b1;
        MemWrite_o = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA_o = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        ALUSrcA_o = SRCA_RS1;
        ALUSrcB_o = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB:     RegWrite_o = 1'b1;
      S_BRANCH: begin
        ALUSrcA_o = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        PCWrite_o = branch_taken(funct3, Zero_i, Lt_i, Ltu_i, BRANCH_FULL != 0);
      end
      S_JALR_ADDR: begin
        ALUSrcA_o = SRCA_RS1;
        ALUSrcB_o = SRCB_IMM;
      end
      S_JUMP: begin
        PCWrite_o = 1'b1;
        ALUSrcA_o = SRCA_OLDPC;
        ALUSrcB_o = SRCB_FOUR;
      end
      S_LUI: begin
        ALUSrcA_o = SRCA_ZERO;
        ALUSrcB_o = SRCB_IMM;
        ImmSrc_o  = IMM_U;
      end
      S_AUIPC: begin
        ALUSrcA_o = SRCA_OLDPC;
        ALUSrcB_o = SRCB_IMM;
        ImmSrc_o  = IMM_U;
      end
      default: ;
    endcase
    // Reset wins combinationally so an aborted instruction never commits a write.
    if (rst_i) begin
      PCWrite_o   = 1'b0;
      AdrSrc_o    = 1'b0;
      IRWrite_o   = 1'b0;
      MemRead_o   = 1'b0;
      MemWrite_o  = 1'b0;
      RegWrite_o  = 1'b0;
      ALUSrcA_o   = 2'b00;
      ALUSrcB_o   = 2'b00;
      alu_op      = ALUOP_ADD;
      ImmSrc_o    = 3'b000;
      ResultSrc_o = 2'b00;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign Illegal_o = (state_q == S_TRAP) && !rst_i;
`endif

  alu_decoder u_alu_decoder (
    .op_i       (opcode),
    .funct3_i   (funct3),
    .funct7_5_i (funct7_5),
    .alu_op_i   (alu_op),
    .ALUCtrl_o  (alu_ctrl)
  );

  assign ALUCtrl_o = ALU_CTRL_W'(alu_ctrl);

endmodule

// File: tb/tb_multicycle_controlunit.sv
// Directed bench for multicycle_controlunit; a second instance runs with reduced branch support.
// Handshake: MemReady_i high during FETCH/MEMREAD/MEMWRITE completes that access on the next rising edge.
module tb_multicycle_controlunit;
  import riscv_ctrl_pkg::*;

  localparam logic [3:0] A_ADD = 4'b0000, A_SUB = 4'b0001, A_AND = 4'b0010, A_OR  = 4'b0011;
  localparam logic [3:0] A_XOR = 4'b0100, A_SLT = 4'b0101, A_SLTU = 4'b0110, A_SRL = 4'b0111;
  localparam logic [3:0] A_SLL = 4'b1000, A_SRA = 4'b1001;

  logic        clk_i;
  logic        rst_i, Zero_i, Lt_i, Ltu_i, MemReady_i;
  logic [31:0] Instr_i;
  logic        PCWrite_o, AdrSrc_o, IRWrite_o, MemRead_o, MemWrite_o, RegWrite_o;
  logic [1:0]  ALUSrcA_o, ALUSrcB_o, ResultSrc_o;
  logic [3:0]  ALUCtrl_o, dbg_state_o;
  logic [2:0]  ImmSrc_o;
  logic        m_PCWrite, m_AdrSrc, m_IRWrite, m_MemRead, m_MemWrite, m_RegWrite;
  logic [1:0]  m_ALUSrcA, m_ALUSrcB, m_ResultSrc;
  logic [3:0]  m_ALUCtrl, m_dbg_state;
  logic [2:0]  m_ImmSrc;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic        Illegal_o, m_Illegal;
`endif
  logic [18:0] ctl, m_ctl;
  int          checks = 0;
  int          errors = 0;

  assign ctl   = {PCWrite_o, AdrSrc_o, IRWrite_o, MemRead_o, MemWrite_o, RegWrite_o,
                  ALUSrcA_o, ALUSrcB_o, ALUCtrl_o, ImmSrc_o, ResultSrc_o};
  assign m_ctl = {m_PCWrite, m_AdrSrc, m_IRWrite, m_MemRead, m_MemWrite, m_RegWrite,
                  m_ALUSrcA, m_ALUSrcB, m_ALUCtrl, m_ImmSrc, m_ResultSrc};

  multicycle_controlunit #(.DATA_WIDTH(32), .ALU_CTRL_W(4), .BRANCH_FULL(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .Instr_i(Instr_i), .Zero_i(Zero_i), .Lt_i(Lt_i), .Ltu_i(Ltu_i),
    .MemReady_i(MemReady_i), .PCWrite_o(PCWrite_o), .AdrSrc_o(AdrSrc_o), .IRWrite_o(IRWrite_o),
    .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .RegWrite_o(RegWrite_o), .ALUSrcA_o(ALUSrcA_o),
    .ALUSrcB_o(ALUSrcB_o), .ALUCtrl_o(ALUCtrl_o), .ImmSrc_o(ImmSrc_o), .ResultSrc_o(ResultSrc_o),
`ifdef CTRL_ILLEGAL_TRAP_EN
    .Illegal_o(Illegal_o),
`endif
    .dbg_state_o(dbg_state_o)
  );

  multicycle_controlunit #(.DATA_WIDTH(32), .ALU_CTRL_W(4), .BRANCH_FULL(0)) dut_min (
    .clk_i(clk_i), .rst_i(rst_i), .Instr_i(Instr_i), .Zero_i(Zero_i), .Lt_i(Lt_i), .Ltu_i(Ltu_i),
    .MemReady_i(MemReady_i), .PCWrite_o(m_PCWrite), .AdrSrc_o(m_AdrSrc), .IRWrite_o(m_IRWrite),
    .MemRead_o(m_MemRead), .MemWrite_o(m_MemWrite), .RegWrite_o(m_RegWrite), .ALUSrcA_o(m_ALUSrcA),
    .ALUSrcB_o(m_ALUSrcB), .ALUCtrl_o(m_ALUCtrl), .ImmSrc_o(m_ImmSrc), .ResultSrc_o(m_ResultSrc),
`ifdef CTRL_ILLEGAL_TRAP_EN
    .Illegal_o(m_Illegal),
`endif
    .dbg_state_o(m_dbg_state)
  );

  // Clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Expected control word builders
  function automatic logic [18:0] cw(input logic pcw, adr, irw, mrd, mwr, rgw,
                                     input logic [1:0] sa, sb, input logic [3:0] alu,
                                     input logic [2:0] imm, input logic [1:0] rs);
    return {pcw, adr, irw, mrd, mwr, rgw, sa, sb, alu, imm, rs};
  endfunction
  function automatic logic [18:0] f_fetch(input logic rdy);
    return cw(rdy, 1'b0, rdy, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, A_ADD, 3'b000, 2'b10);
  endfunction
  function automatic logic [18:0] f_decode(input logic [2:0] imm);
    return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, A_ADD, imm, 2'b00);
  endfunction
  function automatic logic [18:0] f_aluwb();
    return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, A_ADD, 3'b000, 2'b00);
  endfunction

  // Driver: apply one cycle of inputs after the falling edge, then let outputs settle
  task automatic drive(input logic [31:0] instr, input logic rst, rdy, z, lt, ltu);
    @(negedge clk_i);
    Instr_i = instr; rst_i = rst; MemReady_i = rdy; Zero_i = z; Lt_i = lt; Ltu_i = ltu;
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(32'h002081B3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      checks++;
      if (ctl !== 19'd0 || m_ctl !== 19'd0) begin
        errors++;
        $display("FAIL reset_hold_c%0d: ctl=%h m_ctl=%h want 0", c, ctl, m_ctl);
      end
    end
    for (int c = 0; c < 2; c++) begin
      drive(32'h002081B3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (ctl !== f_fetch(1'b0) || dbg_state_o !== S_FETCH) begin
        errors++;
        $display("FAIL reset_fetch_wait_c%0d: ctl=%h st=%0d want ctl=%h st=%0d",
                 c, ctl, dbg_state_o, f_fetch(1'b0), S_FETCH);
      end
    end
  endtask

  task automatic test_alu();
    logic [31:0] ins [14];
    logic [3:0]  alu [14];
    logic [18:0] exp_cw [4];
    logic [3:0]  exp_st [4];
    ins = '{32'h002081B3, 32'h402081B3, 32'h0020F1B3, 32'h4020D1B3, 32'h0020D1B3, 32'h0020A1B3,
            32'h0020B1B3, 32'h002091B3, 32'h0020E1B3, 32'h0020C1B3,
            32'h00108093, 32'h40008093, 32'h4010D093, 32'h0010C093};
    alu = '{A_ADD, A_SUB, A_AND, A_SRA, A_SRL, A_SLT, A_SLTU, A_SLL, A_OR, A_XOR,
            A_ADD, A_ADD, A_SRA, A_XOR};
    for (int k = 0; k < 14; k++) begin
      exp_cw[0] = f_fetch(1'b1);   exp_st[0] = S_FETCH;
      exp_cw[1] = f_decode(3'b010); exp_st[1] = S_DECODE;
      if (k < 10) begin
        exp_cw[2] = cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, alu[k], 3'b000, 2'b00);
        exp_st[2] = S_EXEC_R;
      end else begin
        exp_cw[2] = cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, alu[k], 3'b000, 2'b00);
        exp_st[2] = S_EXEC_I;
      end
      exp_cw[3] = f_aluwb();       exp_st[3] = S_ALUWB;
      for (int c = 0; c < 4; c++) begin
        drive(ins[k], 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl !== exp_cw[c] || dbg_state_o !== exp_st[c]) begin
          errors++;
          $display("FAIL alu_%08h_c%0d: ctl=%h st=%0d want ctl=%h st=%0d",
                   ins[k], c + 1, ctl, dbg_state_o, exp_cw[c], exp_st[c]);
        end
      end
    end
  endtask

  task automatic test_load_wait();
    logic        rdy [8];
    logic [18:0] exp_cw [8];
    logic [3:0]  exp_st [8];
    logic [18:0] mr;
    mr  = cw(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, A_ADD, 3'b000, 2'b00);
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_cw = '{f_fetch(1'b1), f_decode(3'b010),
               cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, A_ADD, 3'b000, 2'b00),
               mr, mr, mr, mr,
               cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, A_ADD, 3'b000, 2'b01)};
    exp_st = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMREAD, S_MEMREAD, S_MEMREAD, S_MEMWB};
    for (int c = 0; c < 8; c++) begin
      drive(32'h0040A183, 1'b0, rdy[c], 1'b0, 1'b0, 1'b0);
      checks++;
      if (ctl !== exp_cw[c] || dbg_state_o !== exp_st[c]) begin
        errors++;
        $display("FAIL lw_wait_c%0d: ctl=%h st=%0d want ctl=%h st=%0d",
                 c + 1, ctl, dbg_state_o, exp_cw[c], exp_st[c]);
      end
    end
  endtask

  task automatic test_branch();
    logic [31:0] ins [6];
    logic        z [6], lt [6], ltu [6], tk_full [6], tk_min [6];
    logic [18:0] exp_cw, exp_m;
    logic [3:0]  exp_st;
    ins     = '{32'h0020C063, 32'h0020F063, 32'h00208063, 32'h00209063, 32'h0020D063, 32'h0020A063};
    z       = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    lt      = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ltu     = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tk_full = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tk_min  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 3; c++) begin
        drive(ins[k], 1'b0, 1'b1, z[k], lt[k], ltu[k]);
        case (c)
          0: begin exp_cw = f_fetch(1'b1); exp_m = exp_cw; exp_st = S_FETCH; end
          1: begin exp_cw = f_decode(3'b010); exp_m = exp_cw; exp_st = S_DECODE; end
          default: begin
            exp_cw = cw(tk_full[k], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, A_SUB, 3'b000, 2'b00);
            exp_m  = cw(tk_min[k], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, A_SUB, 3'b000, 2'b00);
            exp_st = S_BRANCH;
          end
        endcase
        checks++;
        if (ctl !== exp_cw || m_ctl !== exp_m || dbg_state_o !== exp_st || m_dbg_state !== exp_st) begin
          errors++;
          $display("FAIL branch_%08h_c%0d: ctl=%h m_ctl=%h st=%0d want ctl=%h m_ctl=%h st=%0d",
                   ins[k], c + 1, ctl, m_ctl, dbg_state_o, exp_cw, exp_m, exp_st);
        end
      end
    end
  endtask

  task automatic test_jump();
    logic [31:0] ins;
    logic [18:0] exp_cw [5];
    logic [3:0]  exp_st [5];
    logic [18:0] jmp;
    int          n;
    jmp = cw(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, A_ADD, 3'b000, 2'b00);
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        ins = 32'h000080E7; n = 5;
        exp_cw = '{f_fetch(1'b1), f_decode(3'b010),
                   cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, A_ADD, 3'b000, 2'b00),
                   jmp, f_aluwb()};
        exp_st = '{S_FETCH, S_DECODE, S_JALR_ADDR, S_JUMP, S_ALUWB};
      end else begin
        ins = 32'h0000006F; n = 4;
        exp_cw = '{f_fetch(1'b1), f_decode(3'b100), jmp, f_aluwb(), 19'd0};
        exp_st = '{S_FETCH, S_DECODE, S_JUMP, S_ALUWB, S_FETCH};
      end
      for (int c = 0; c < n; c++) begin
        drive(ins, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl !== exp_cw[c] || dbg_state_o !== exp_st[c]) begin
          errors++;
          $display("FAIL jump_%08h_c%0d: ctl=%h st=%0d want ctl=%h st=%0d",
                   ins, c + 1, ctl, dbg_state_o, exp_cw[c], exp_st[c]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [3];
    logic [18:0] exp_cw [3][4];
    logic [3:0]  exp_st [3][4];
    ins = '{32'h000010B7, 32'h00001097, 32'h0020A023};
    exp_cw[0] = '{f_fetch(1'b1), f_decode(3'b010),
                  cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b01, A_ADD, 3'b011, 2'b00), f_aluwb()};
    exp_st[0] = '{S_FETCH, S_DECODE, S_LUI, S_ALUWB};
    exp_cw[1] = '{f_fetch(1'b1), f_decode(3'b010),
                  cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, A_ADD, 3'b011, 2'b00), f_aluwb()};
    exp_st[1] = '{S_FETCH, S_DECODE, S_AUIPC, S_ALUWB};
    exp_cw[2] = '{f_fetch(1'b1), f_decode(3'b010),
                  cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, A_ADD, 3'b001, 2'b00),
                  cw(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, A_ADD, 3'b000, 2'b00)};
    exp_st[2] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE};
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 4; c++) begin
        drive(ins[k], 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctl !== exp_cw[k][c] || dbg_state_o !== exp_st[k][c]) begin
          errors++;
          $display("FAIL b2b_%08h_c%0d: ctl=%h st=%0d want ctl=%h st=%0d",
                   ins[k], c + 1, ctl, dbg_state_o, exp_cw[k][c], exp_st[k][c]);
        end
      end
    end
  endtask

  task automatic test_store_reset();
    logic [18:0] exp_cw [6];
    logic [3:0]  exp_st [6];
    logic        rst [6], rdy [6];
    logic [18:0] mw;
    mw  = cw(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, A_ADD, 3'b000, 2'b00);
    rst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_cw = '{f_fetch(1'b1), f_decode(3'b010),
               cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, A_ADD, 3'b001, 2'b00),
               mw, 19'd0, f_fetch(1'b0)};
    exp_st = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE, S_MEMWRITE, S_FETCH};
    for (int c = 0; c < 6; c++) begin
      drive(32'h0020A023, rst[c], rdy[c], 1'b0, 1'b0, 1'b0);
      checks++;
      if (ctl !== exp_cw[c] || dbg_state_o !== exp_st[c]) begin
        errors++;
        $display("FAIL sw_reset_c%0d: ctl=%h st=%0d want ctl=%h st=%0d",
                 c + 1, ctl, dbg_state_o, exp_cw[c], exp_st[c]);
      end
    end
  endtask

  task automatic test_illegal();
    drive(32'h0000007F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl !== f_fetch(1'b1) || dbg_state_o !== S_FETCH) begin
      errors++;
      $display("FAIL illegal_fetch: ctl=%h st=%0d want ctl=%h st=%0d", ctl, dbg_state_o, f_fetch(1'b1), S_FETCH);
    end
    drive(32'h0000007F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl !== f_decode(3'b010) || dbg_state_o !== S_DECODE) begin
      errors++;
      $display("FAIL illegal_decode: ctl=%h st=%0d want ctl=%h st=%0d", ctl, dbg_state_o, f_decode(3'b010), S_DECODE);
    end
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int c = 0; c < 3; c++) begin
      drive(32'h0000007F, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      checks++;
      if (ctl !== 19'd0 || Illegal_o !== 1'b1 || m_Illegal !== 1'b1 || dbg_state_o !== S_TRAP) begin
        errors++;
        $display("FAIL trap_hold_c%0d: ctl=%h ill=%b st=%0d want ctl=0 ill=1 st=%0d",
                 c, ctl, Illegal_o, dbg_state_o, S_TRAP);
      end
    end
    drive(32'h0000007F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl !== 19'd0 || Illegal_o !== 1'b0) begin
      errors++;
      $display("FAIL trap_reset: ctl=%h ill=%b want ctl=0 ill=0", ctl, Illegal_o);
    end
    drive(32'h0000007F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl !== f_fetch(1'b0) || Illegal_o !== 1'b0 || dbg_state_o !== S_FETCH) begin
      errors++;
      $display("FAIL trap_cleared: ctl=%h ill=%b st=%0d want ctl=%h ill=0 st=%0d",
               ctl, Illegal_o, dbg_state_o, f_fetch(1'b0), S_FETCH);
    end
`else
    drive(32'h0000007F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl !== f_fetch(1'b0) || dbg_state_o !== S_FETCH) begin
      errors++;
      $display("FAIL illegal_nop_fetch: ctl=%h st=%0d want ctl=%h st=%0d",
               ctl, dbg_state_o, f_fetch(1'b0), S_FETCH);
    end
`endif
  endtask

  initial begin
    rst_i = 1'b1; MemReady_i = 1'b0; Zero_i = 1'b0; Lt_i = 1'b0; Ltu_i = 1'b0;
    Instr_i = 32'h0;
    test_reset();
    test_alu();
    test_load_wait();
    test_branch();
    test_jump();
    test_back_to_back();
    test_store_reset();
    test_illegal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
